seq_canon_ctrl: RTL

SEQ_CANON_CTRL -- requirements
Module: seq_canon_ctrl

---
 rtl/seq_pkg.sv | 32 +++
 rtl/seq_voice.sv | 135 +++++++++++++
 rtl/seq_canon_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the two-voice canon sequencer: note codes, song ROM
// field layout and the per-voice state enum.
package seq_pkg;

    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 8;
    localparam int NOTE_W   = 4;
    localparam int DUR_W    = 4;
    localparam int NOTE_LSB = 4;
    localparam int DUR_LSB  = 0;

    localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
    localparam logic [NOTE_W-1:0] DO_4      = 4'd1;
    localparam logic [NOTE_W-1:0] RE_4      = 4'd2;
    localparam logic [NOTE_W-1:0] MI_4      = 4'd3;
    localparam logic [NOTE_W-1:0] FA_4      = 4'd4;
    localparam logic [NOTE_W-1:0] SO_4      = 4'd5;
    localparam logic [NOTE_W-1:0] LA_4      = 4'd6;
    localparam logic [NOTE_W-1:0] TI_4      = 4'd7;
    localparam logic [NOTE_W-1:0] DO_5      = 4'd8;

    typedef enum logic [2:0] {IDLE, WAIT, FETCH, PLAY, DONE} voice_state_t;

    function automatic logic [NOTE_W-1:0] rom_note(input logic [DATA_W-1:0] d);
        return d[NOTE_LSB +: NOTE_W];
    endfunction

    function automatic logic [DUR_W-1:0] rom_dur(input logic [DATA_W-1:0] d);
        return d[DUR_LSB +: DUR_W];
    endfunction

endpackage

// File: rtl/seq_voice.sv
// One sequencer voice: lag wait, ROM fetch handshake, note hold and duration
// countdown. The gap input shortens the tone enable on a note's final beat.
module seq_voice
    import seq_pkg::*;
#(
    parameter int LAG = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              go,
    input  logic              clr,
    input  logic              beat,
    input  logic              gap,
    input  logic              loop_en,
    input  logic              gnt,
    input  logic [DATA_W-1:0] rom_data,
    output logic              req,
    output logic [ADDR_W-1:0] addr,
    output logic [NOTE_W-1:0] note,
    output logic              en,
    output logic              done
);

    voice_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic [DUR_W-1:0]  rem_reg, rem_next;
    logic [5:0]        wait_reg, wait_next;
    logic              pend_reg, pend_next;
    logic [NOTE_W-1:0] note_reg, note_next;
    logic              en_reg, en_next;
    logic [NOTE_W-1:0] rd_note;
    logic [DUR_W-1:0]  rd_dur;
    logic              relaunch;

    assign rd_note = rom_note(rom_data);
    assign rd_dur  = rom_dur(rom_data);

    // A looping end marker requests address 0 in its own capture cycle.
    assign relaunch = (state_reg == FETCH) && pend_reg && (rd_dur == '0) && loop_en;
    assign req      = ((state_reg == FETCH) && !pend_reg) || relaunch;
    assign addr     = relaunch ? '0 : ptr_reg;
    assign note     = note_reg;
    assign en       = en_reg && !(gap && (state_reg == PLAY) && (rem_reg == DUR_W'(1)));
    assign done     = (state_reg == DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            rem_reg   <= '0;
            wait_reg  <= '0;
            pend_reg  <= 1'b0;
            note_reg  <= NOTE_REST;
            en_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            rem_reg   <= rem_next;
            wait_reg  <= wait_next;
            pend_reg  <= pend_next;
            note_reg  <= note_next;
            en_reg    <= en_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        rem_next   = rem_reg;
        wait_next  = wait_reg;
        pend_next  = pend_reg;
        note_next  = note_reg;
        en_next    = en_reg;
        if (clr) begin
            state_next = IDLE;
            ptr_next   = '0;
            rem_next   = '0;
            wait_next  = '0;
            pend_next  = 1'b0;
            note_next  = NOTE_REST;
            en_next    = 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (go) begin
                    ptr_next   = '0;
                    state_next = (LAG == 0) ? FETCH : WAIT;
                end
                WAIT: if (beat) begin
                    if (wait_reg == 6'(LAG - 1)) begin
                        wait_next  = '0;
                        state_next = FETCH;
                    end else begin
                        wait_next = wait_reg + 6'd1;
                    end
                end
                FETCH: begin
                    if (pend_reg) begin
                        if (rd_dur == '0) begin
                            if (loop_en) begin
                                // Lost arbitration on relaunch: retry as a normal request.
                                ptr_next  = '0;
                                pend_next = gnt;
                            end else begin
                                pend_next  = 1'b0;
                                state_next = DONE;
                                note_next  = NOTE_REST;
                                en_next    = 1'b0;
                            end
                        end else begin
                            pend_next  = 1'b0;
                            note_next  = rd_note;
                            en_next    = (rd_note != NOTE_REST);
                            rem_next   = rd_dur;
                            state_next = PLAY;
                        end
                    end else if (gnt) begin
                        pend_next = 1'b1;
                    end
                end
                PLAY: if (beat) begin
                    if (rem_reg == DUR_W'(1)) begin
                        rem_next   = '0;
                        ptr_next   = ptr_reg + ADDR_W'(1);
                        state_next = FETCH;
                    end else begin
                        rem_next = rem_reg - DUR_W'(1);
                    end
                end
                DONE: ;
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/seq_canon_ctrl.sv
// Two-voice canon player: beat divider, fixed-priority song ROM arbiter and two
// seq_voice instances. Define SEQ_GAP_EN for an articulation gap at note ends.
module seq_canon_ctrl
    import seq_pkg::*;
#(
    parameter int TICK_DIV = 6000000,
    parameter int LAG      = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [NOTE_W-1:0] note0,
    output logic [NOTE_W-1:0] note1,
    output logic              en0,
    output logic              en1,
    output logic              beat,
    output logic              busy
);

    localparam int TW = $clog2(TICK_DIV);

    logic [TW-1:0]     tick_reg, tick_next;
    logic              busy_reg, busy_next;
    logic              go, tick_last, gap, all_done, clr;
    logic [1:0]        req, gnt, done, en_v;
    logic [ADDR_W-1:0] addr_v [2];
    logic [NOTE_W-1:0] note_v [2];

    assign go        = start && !stop && !busy_reg;
    assign tick_last = (tick_reg == TW'(TICK_DIV - 1));
    assign all_done  = &done;
    assign clr       = stop || all_done;
    assign beat      = busy_reg && tick_last;
    assign busy      = busy_reg;

`ifdef SEQ_GAP_EN
    assign gap = busy_reg && (tick_reg >= TW'(TICK_DIV - TICK_DIV / 8));
`else
    assign gap = 1'b0;
`endif

    // Voice 0 always wins; voice 1 slips in while voice 0 captures its data.
    assign gnt[0]   = req[0];
    assign gnt[1]   = req[1] && !req[0];
    assign rom_addr = req[0] ? addr_v[0] : (req[1] ? addr_v[1] : '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tick_reg <= '0;
            busy_reg <= 1'b0;
        end else begin
            tick_reg <= tick_next;
            busy_reg <= busy_next;
        end
    end

    always_comb begin
        tick_next = tick_reg + TW'(1);
        busy_next = busy_reg;
        if (stop || go || !busy_reg || all_done || tick_last) begin
            tick_next = '0;
        end
        if (stop || all_done) begin
            busy_next = 1'b0;
        end else if (go) begin
            busy_next = 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_voice
            seq_voice #(
                .LAG ((gi == 0) ? 0 : LAG)
            ) u_voice (
                .clk      (clk),
                .rstn     (rstn),
                .go       (go),
                .clr      (clr),
                .beat     (beat),
                .gap      (gap),
                .loop_en  (loop_en),
                .gnt      (gnt[gi]),
                .rom_data (rom_data),
                .req      (req[gi]),
                .addr     (addr_v[gi]),
                .note     (note_v[gi]),
                .en       (en_v[gi]),
                .done     (done[gi])
            );
        end
    endgenerate

    assign note0 = note_v[0];
    assign note1 = note_v[1];
    assign en0   = en_v[0];
    assign en1   = en_v[1];

endmodule
